// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_stage_pkg;

  // Default bubble encoding: addi x0, x0, 0
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  // Fetch FSM: issue a request, wait for its response, or discard a squashed one
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  // Sequential successor of a word address; wraps modulo 2^32
  function automatic logic [31:0] next_word(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_fetch_skid_buf.sv
// One-entry holding buffer for an instruction that arrives while IF/ID is stalled.
// Clear beats load, load beats drain.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_drain,
  input  logic        i_clear,
  input  logic [31:0] i_ir,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  output logic [31:0] o_ir,
  output logic [31:0] o_pc
);

  logic        r_valid;
  logic [31:0] r_ir;
  logic [31:0] r_pc;

  // Entry bookkeeping: a redirect empties it, a parked response fills it, IF/ID drains it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ir    <= '0;
      r_pc    <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_ir    <= i_ir;
      r_pc    <= i_pc;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_ir    = r_ir;
  assign o_pc    = r_pc;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, drives a single-outstanding instruction
// memory port, and produces the IF/ID pipeline register for the decode stage.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_stall_flag,
  input  logic        ex_take_branch,
  input  logic [31:0] ex_target_pc,
  input  logic        Imem2proc_valid,
  input  logic [31:0] Imem2proc_data,
  output logic        proc2Imem_req,
  output logic [31:0] proc2Imem_addr,
  output logic [31:0] if_id_IR,
  output logic [31:0] if_id_PC,
  output logic [31:0] if_id_NPC,
  output logic        if_id_valid_inst
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic [31:0]  r_pc;
  logic         w_req;
  logic         w_deliver;
  logic         w_buf_valid;
  logic [31:0]  w_buf_ir;
  logic [31:0]  w_buf_pc;
  logic         w_buf_load;
  logic         w_buf_drain;

  logic [31:0]  r_if_id_ir;
  logic [31:0]  r_if_id_pc;
  logic [31:0]  r_if_id_npc;
  logic         r_if_id_valid;

  // Fetch FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_REQ;
    else     r_state <= w_state_next;
  end

  // Fetch FSM next state; the request strobe depends only on state and buffer occupancy
  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    w_deliver    = 1'b0;
    case (r_state)
      S_REQ: begin
        // A full buffer blocks new requests; a redirect keeps us here so the
        // following request uses the target address.
        w_req = !w_buf_valid;
        if (w_req && !ex_take_branch) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (Imem2proc_valid) begin
          w_state_next = S_REQ;
          w_deliver    = !ex_take_branch;
        end else if (ex_take_branch) begin
          w_state_next = S_DROP;
        end
      end
      S_DROP: begin
        // The squashed response frees the memory port even if another
        // redirect lands in the same cycle; the PC already holds the target.
        if (Imem2proc_valid) w_state_next = S_REQ;
      end
      default: w_state_next = S_REQ;
    endcase
  end

  // Program counter: redirect target wins over sequential advance on delivery
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r_pc <= RESET_PC;
    else if (ex_take_branch) r_pc <= ex_target_pc;
    else if (w_deliver)      r_pc <= next_word(r_pc);
  end

  // A delivered instruction parks in the buffer when IF/ID cannot take it now
  assign w_buf_load  = w_deliver && (id_stall_flag || w_buf_valid);
  assign w_buf_drain = !ex_take_branch && !id_stall_flag && w_buf_valid;

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_buf_load),
    .i_drain (w_buf_drain),
    .i_clear (ex_take_branch),
    .i_ir    (Imem2proc_data),
    .i_pc    (r_pc),
    .o_valid (w_buf_valid),
    .o_ir    (w_buf_ir),
    .o_pc    (w_buf_pc)
  );

  // IF/ID register: flush > stall hold > buffered entry > fresh response > bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_id_ir    <= NOP_INST;
      r_if_id_pc    <= '0;
      r_if_id_npc   <= '0;
      r_if_id_valid <= 1'b0;
    end else if (ex_take_branch) begin
      r_if_id_ir    <= NOP_INST;
      r_if_id_valid <= 1'b0;
    end else if (id_stall_flag) begin
      r_if_id_ir    <= r_if_id_ir;
      r_if_id_valid <= r_if_id_valid;
    end else if (w_buf_valid) begin
      r_if_id_ir    <= w_buf_ir;
      r_if_id_pc    <= w_buf_pc;
      r_if_id_npc   <= next_word(w_buf_pc);
      r_if_id_valid <= 1'b1;
    end else if (w_deliver) begin
      r_if_id_ir    <= Imem2proc_data;
      r_if_id_pc    <= r_pc;
      r_if_id_npc   <= next_word(r_pc);
      r_if_id_valid <= 1'b1;
    end else begin
      r_if_id_ir    <= NOP_INST;
      r_if_id_valid <= 1'b0;
    end
  end

  assign proc2Imem_req    = w_req;
  assign proc2Imem_addr   = r_pc;
  assign if_id_IR         = r_if_id_ir;
  assign if_id_PC         = r_if_id_pc;
  assign if_id_NPC        = r_if_id_npc;
  assign if_id_valid_inst = r_if_id_valid;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized run
// checked against an in-order instruction-stream model.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_stall_flag;
  logic        ex_take_branch;
  logic [31:0] ex_target_pc;
  logic        Imem2proc_valid;
  logic [31:0] Imem2proc_data;
  logic        proc2Imem_req;
  logic [31:0] proc2Imem_addr;
  logic [31:0] if_id_IR;
  logic [31:0] if_id_PC;
  logic [31:0] if_id_NPC;
  logic        if_id_valid_inst;

  int n_pass   = 0;
  int n_checks = 0;

  // memory model controls
  int          mem_lat  = 1;
  logic        mem_rand = 1'b0;
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;

  if_stage dut (
    .clk              (clk),
    .rst              (rst),
    .id_stall_flag    (id_stall_flag),
    .ex_take_branch   (ex_take_branch),
    .ex_target_pc     (ex_target_pc),
    .Imem2proc_valid  (Imem2proc_valid),
    .Imem2proc_data   (Imem2proc_data),
    .proc2Imem_req    (proc2Imem_req),
    .proc2Imem_addr   (proc2Imem_addr),
    .if_id_IR         (if_id_IR),
    .if_id_PC         (if_id_PC),
    .if_id_NPC        (if_id_NPC),
    .if_id_valid_inst (if_id_valid_inst)
  );

  always #5 clk = ~clk;

  // program image: a distinct word per address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // single-outstanding memory with fixed or random latency; drops pending on reset
  assign Imem2proc_valid = mem_busy && (mem_cnt == 1);
  assign Imem2proc_data  = mem_word(mem_addr);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_busy <= 1'b0;
      mem_cnt  <= 0;
      mem_addr <= '0;
    end else begin
      if (mem_busy) begin
        if (mem_cnt == 1) mem_busy <= 1'b0;
        else              mem_cnt  <= mem_cnt - 1;
      end
      if (proc2Imem_req && (!mem_busy || mem_cnt == 1)) begin
        mem_busy <= 1'b1;
        mem_cnt  <= mem_rand ? int'($urandom_range(1, 4)) : mem_lat;
        mem_addr <= proc2Imem_addr;
      end
    end
  end

  task automatic apply_reset();
    rst            = 1'b1;
    id_stall_flag  = 1'b0;
    ex_take_branch = 1'b0;
    ex_target_pc   = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // reset with 1-cycle memory, then advance to the cycle where the PC=8 response is present
  task automatic run_to_c5();
    mem_rand = 1'b0;
    mem_lat  = 1;
    apply_reset();
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    id_stall_flag  = 1'b0;
    ex_take_branch = 1'b0;
    ex_target_pc   = '0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (if_id_valid_inst !== 1'b0) $display("FAIL reset_valid got %b want 0", if_id_valid_inst); else n_pass++;
    n_checks++; if (if_id_IR !== NOP) $display("FAIL reset_ir got %h want %h", if_id_IR, NOP); else n_pass++;
    n_checks++; if (if_id_PC !== 32'h0 || if_id_NPC !== 32'h0) $display("FAIL reset_pc_npc got %h/%h want 0/0", if_id_PC, if_id_NPC); else n_pass++;
    n_checks++; if (proc2Imem_req !== 1'b1 || proc2Imem_addr !== 32'h0) $display("FAIL reset_req got %b@%h want 1@0", proc2Imem_req, proc2Imem_addr); else n_pass++;
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_fetch_seq();
    logic [31:0] exp_pc;
    mem_rand = 1'b0;
    mem_lat  = 1;
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      n_checks++; if (proc2Imem_req !== (k % 2 == 0)) $display("FAIL seq_req k=%0d got %b want %b", k, proc2Imem_req, (k % 2 == 0)); else n_pass++;
      n_checks++; if (proc2Imem_addr !== 32'(4 * (k / 2))) $display("FAIL seq_addr k=%0d got %h want %h", k, proc2Imem_addr, 32'(4 * (k / 2))); else n_pass++;
      if (k >= 2 && k % 2 == 0) begin
        exp_pc = 32'(4 * (k / 2 - 1));
        n_checks++; if (if_id_valid_inst !== 1'b1 || if_id_PC !== exp_pc) $display("FAIL seq_ifid k=%0d got %b/%h want 1/%h", k, if_id_valid_inst, if_id_PC, exp_pc); else n_pass++;
        n_checks++; if (if_id_NPC !== exp_pc + 32'd4 || if_id_IR !== mem_word(exp_pc)) $display("FAIL seq_ir_npc k=%0d got %h/%h want %h/%h", k, if_id_IR, if_id_NPC, mem_word(exp_pc), exp_pc + 32'd4); else n_pass++;
      end else begin
        n_checks++; if (if_id_valid_inst !== 1'b0 || if_id_IR !== NOP) $display("FAIL seq_bubble k=%0d got %b/%h want 0/%h", k, if_id_valid_inst, if_id_IR, NOP); else n_pass++;
      end
      $display("seq cycle %0d req=%b addr=%h valid=%b pc=%h", k, proc2Imem_req, proc2Imem_addr, if_id_valid_inst, if_id_PC);
      @(negedge clk);
    end
  endtask

  task automatic test_stall_buffer();
    run_to_c5();
    id_stall_flag = 1'b1;
    for (int k = 6; k <= 8; k++) begin
      @(negedge clk);
      n_checks++; if (if_id_PC !== 32'h4 || if_id_valid_inst !== 1'b0) $display("FAIL stall_hold c%0d got %h/%b want 4/0", k, if_id_PC, if_id_valid_inst); else n_pass++;
      n_checks++; if (proc2Imem_req !== 1'b0) $display("FAIL stall_noreq c%0d got %b want 0", k, proc2Imem_req); else n_pass++;
    end
    id_stall_flag = 1'b0;
    @(negedge clk);
    n_checks++; if (if_id_valid_inst !== 1'b1 || if_id_PC !== 32'h8) $display("FAIL stall_release got %b/%h want 1/8", if_id_valid_inst, if_id_PC); else n_pass++;
    n_checks++; if (if_id_IR !== mem_word(32'h8) || if_id_NPC !== 32'hC) $display("FAIL stall_release_ir got %h/%h want %h/c", if_id_IR, if_id_NPC, mem_word(32'h8)); else n_pass++;
    n_checks++; if (proc2Imem_req !== 1'b1 || proc2Imem_addr !== 32'hC) $display("FAIL stall_resume got %b@%h want 1@c", proc2Imem_req, proc2Imem_addr); else n_pass++;
    $display("test_stall_buffer done pc=%h", if_id_PC);
  endtask

  task automatic test_redirect_wait();
    logic found;
    mem_rand = 1'b0;
    mem_lat  = 3;
    apply_reset();
    @(negedge clk);
    ex_take_branch = 1'b1;
    ex_target_pc   = 32'h100;
    @(negedge clk);
    ex_take_branch = 1'b0;
    n_checks++; if (proc2Imem_req !== 1'b0) $display("FAIL rdw_drop_noreq got %b want 0", proc2Imem_req); else n_pass++;
    n_checks++; if (if_id_valid_inst !== 1'b0 || if_id_IR !== NOP) $display("FAIL rdw_bubble got %b/%h want 0/%h", if_id_valid_inst, if_id_IR, NOP); else n_pass++;
    @(negedge clk);
    n_checks++; if (proc2Imem_req !== 1'b0) $display("FAIL rdw_drop_noreq2 got %b want 0", proc2Imem_req); else n_pass++;
    @(negedge clk);
    n_checks++; if (proc2Imem_req !== 1'b1 || proc2Imem_addr !== 32'h100) $display("FAIL rdw_target_req got %b@%h want 1@100", proc2Imem_req, proc2Imem_addr); else n_pass++;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (if_id_valid_inst === 1'b1) found = 1'b1;
    end
    n_checks++; if (!found) $display("FAIL rdw_timeout got no valid want valid within 12 cycles"); else n_pass++;
    n_checks++; if (if_id_PC !== 32'h100 || if_id_IR !== mem_word(32'h100)) $display("FAIL rdw_first got %h/%h want 100/%h", if_id_PC, if_id_IR, mem_word(32'h100)); else n_pass++;
    $display("test_redirect_wait done pc=%h", if_id_PC);
  endtask

  task automatic test_redirect_stall_buf();
    run_to_c5();
    id_stall_flag = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ex_take_branch = 1'b1;
    ex_target_pc   = 32'h200;
    @(negedge clk);
    n_checks++; if (if_id_valid_inst !== 1'b0 || if_id_IR !== NOP) $display("FAIL rsb_flush got %b/%h want 0/%h", if_id_valid_inst, if_id_IR, NOP); else n_pass++;
    n_checks++; if (proc2Imem_req !== 1'b1 || proc2Imem_addr !== 32'h200) $display("FAIL rsb_req got %b@%h want 1@200", proc2Imem_req, proc2Imem_addr); else n_pass++;
    id_stall_flag  = 1'b0;
    ex_take_branch = 1'b0;
    @(negedge clk);
    n_checks++; if (if_id_valid_inst !== 1'b0) $display("FAIL rsb_buf_cleared got %b/%h want 0", if_id_valid_inst, if_id_PC); else n_pass++;
    @(negedge clk);
    n_checks++; if (if_id_valid_inst !== 1'b1 || if_id_PC !== 32'h200 || if_id_NPC !== 32'h204) $display("FAIL rsb_target got %b/%h/%h want 1/200/204", if_id_valid_inst, if_id_PC, if_id_NPC); else n_pass++;
    n_checks++; if (if_id_IR !== mem_word(32'h200)) $display("FAIL rsb_target_ir got %h want %h", if_id_IR, mem_word(32'h200)); else n_pass++;
    $display("test_redirect_stall_buf done pc=%h", if_id_PC);
  endtask

  task automatic test_redirect_resp();
    mem_rand = 1'b0;
    mem_lat  = 1;
    apply_reset();
    @(negedge clk);
    ex_take_branch = 1'b1;
    ex_target_pc   = 32'h300;
    @(negedge clk);
    ex_take_branch = 1'b0;
    n_checks++; if (if_id_valid_inst !== 1'b0 || if_id_IR !== NOP) $display("FAIL rr_discard got %b/%h want 0/%h", if_id_valid_inst, if_id_IR, NOP); else n_pass++;
    n_checks++; if (proc2Imem_req !== 1'b1 || proc2Imem_addr !== 32'h300) $display("FAIL rr_req got %b@%h want 1@300", proc2Imem_req, proc2Imem_addr); else n_pass++;
    @(negedge clk);
    n_checks++; if (if_id_valid_inst !== 1'b0) $display("FAIL rr_no_stale got %b/%h want 0", if_id_valid_inst, if_id_PC); else n_pass++;
    @(negedge clk);
    n_checks++; if (if_id_valid_inst !== 1'b1 || if_id_PC !== 32'h300 || if_id_IR !== mem_word(32'h300)) $display("FAIL rr_target got %b/%h/%h want 1/300/%h", if_id_valid_inst, if_id_PC, if_id_IR, mem_word(32'h300)); else n_pass++;
    $display("test_redirect_resp done pc=%h", if_id_PC);
  endtask

  task automatic test_reset_mid();
    logic found;
    mem_rand = 1'b0;
    mem_lat  = 3;
    apply_reset();
    repeat (4) @(negedge clk);
    n_checks++; if (if_id_valid_inst !== 1'b1 || if_id_PC !== 32'h0) $display("FAIL rm_pre got %b/%h want 1/0", if_id_valid_inst, if_id_PC); else n_pass++;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (if_id_valid_inst !== 1'b0 || if_id_IR !== NOP) $display("FAIL rm_async_ifid got %b/%h want 0/%h", if_id_valid_inst, if_id_IR, NOP); else n_pass++;
    n_checks++; if (if_id_PC !== 32'h0 || if_id_NPC !== 32'h0) $display("FAIL rm_async_pc got %h/%h want 0/0", if_id_PC, if_id_NPC); else n_pass++;
    n_checks++; if (proc2Imem_req !== 1'b1 || proc2Imem_addr !== 32'h0) $display("FAIL rm_async_req got %b@%h want 1@0", proc2Imem_req, proc2Imem_addr); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (proc2Imem_req !== 1'b1 || proc2Imem_addr !== 32'h0) $display("FAIL rm_first_req got %b@%h want 1@0", proc2Imem_req, proc2Imem_addr); else n_pass++;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (if_id_valid_inst === 1'b1) found = 1'b1;
    end
    n_checks++; if (!found) $display("FAIL rm_timeout got no valid want valid within 12 cycles"); else n_pass++;
    n_checks++; if (if_id_PC !== 32'h0 || if_id_IR !== mem_word(32'h0)) $display("FAIL rm_first got %h/%h want 0/%h", if_id_PC, if_id_IR, mem_word(32'h0)); else n_pass++;
    $display("test_reset_mid done pc=%h", if_id_PC);
  endtask

  // Model: IF/ID shows the program stream in order, restarting at each redirect
  // target; a stall freezes it, a redirect bubbles it.
  task automatic test_random();
    logic [31:0] exp_next;
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic        prev_stall;
    logic        prev_br;
    logic [31:0] tmp;
    int          delivered;
    mem_rand = 1'b1;
    apply_reset();
    exp_next   = 32'h0;
    m_valid    = 1'b0;
    m_pc       = '0;
    m_ir       = NOP;
    prev_stall = 1'b0;
    prev_br    = 1'b0;
    delivered  = 0;
    for (int i = 0; i < 600; i++) begin
      if (prev_br) begin
        n_checks++; if ({if_id_valid_inst, if_id_IR} !== {1'b0, NOP}) $display("FAIL rnd_flush i=%0d got %b/%h want 0/%h", i, if_id_valid_inst, if_id_IR, NOP); else n_pass++;
        m_valid = 1'b0;
      end else if (prev_stall) begin
        n_checks++; if (if_id_valid_inst !== m_valid) $display("FAIL rnd_hold_valid i=%0d got %b want %b", i, if_id_valid_inst, m_valid); else n_pass++;
        if (m_valid) begin
          n_checks++; if (if_id_PC !== m_pc || if_id_IR !== m_ir) $display("FAIL rnd_hold i=%0d got %h/%h want %h/%h", i, if_id_PC, if_id_IR, m_pc, m_ir); else n_pass++;
        end else begin
          n_checks++; if (if_id_IR !== NOP) $display("FAIL rnd_hold_nop i=%0d got %h want %h", i, if_id_IR, NOP); else n_pass++;
        end
      end else if (if_id_valid_inst === 1'b1) begin
        n_checks++; if (if_id_PC !== exp_next || if_id_IR !== mem_word(exp_next)) $display("FAIL rnd_order i=%0d got %h/%h want %h/%h", i, if_id_PC, if_id_IR, exp_next, mem_word(exp_next)); else n_pass++;
        n_checks++; if (if_id_NPC !== exp_next + 32'd4) $display("FAIL rnd_npc i=%0d got %h want %h", i, if_id_NPC, exp_next + 32'd4); else n_pass++;
        $display("rnd deliver i=%0d pc=%h ir=%h", i, if_id_PC, if_id_IR);
        m_valid   = 1'b1;
        m_pc      = exp_next;
        m_ir      = mem_word(exp_next);
        exp_next  = exp_next + 32'd4;
        delivered++;
      end else begin
        n_checks++; if (if_id_IR !== NOP) $display("FAIL rnd_bubble i=%0d got %h want %h", i, if_id_IR, NOP); else n_pass++;
        m_valid = 1'b0;
      end
      // next cycle's stimulus; redirects only when no request is being issued
      id_stall_flag  = ($urandom_range(0, 3) == 0);
      ex_take_branch = (proc2Imem_req === 1'b0) && ($urandom_range(0, 11) == 0);
      if (ex_take_branch) begin
        tmp = $urandom();
        ex_target_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : (tmp & 32'h0000_FFFC);
        exp_next     = ex_target_pc;
        $display("rnd redirect i=%0d target=%h", i, ex_target_pc);
      end
      prev_stall = id_stall_flag;
      prev_br    = ex_take_branch;
      @(negedge clk);
    end
    id_stall_flag  = 1'b0;
    ex_take_branch = 1'b0;
    n_checks++; if (delivered < 20) $display("FAIL rnd_progress got %0d deliveries want >= 20", delivered); else n_pass++;
    $display("test_random done deliveries=%0d", delivered);
  endtask

  initial begin
    test_reset();
    test_fetch_seq();
    test_stall_buffer();
    test_redirect_wait();
    test_redirect_stall_buf();
    test_redirect_resp();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
